// File: rtl/ram_pkg.sv
// Shared types and the round-robin selection function for the RAM port arbiter.
package ram_pkg;

    localparam int DATA_WIDTH_DEF = 64;
    localparam int ADDR_WIDTH_DEF = 12;
    // Widest requester set the selection function handles.
    localparam int MAX_REQ        = 8;

    typedef logic [ADDR_WIDTH_DEF-1:0] addr_t;
    typedef logic [DATA_WIDTH_DEF-1:0] data_t;

    // One-hot grant: first asserted request at or after ptr, wrapping modulo n.
    // ptr is always < n, so a single subtraction performs the wrap.
    function automatic logic [MAX_REQ-1:0] rr_select(
        input logic [MAX_REQ-1:0] req,
        input logic [2:0]         ptr,
        input logic [3:0]         n
    );
        logic [MAX_REQ-1:0] gnt;
        logic [3:0]         idx;
        logic               found;
        gnt   = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (4'(k) < n) begin
                idx = {1'b0, ptr} + 4'(k);
                if (idx >= n) idx = idx - n;
                if (!found && req[idx[2:0]]) begin
                    gnt[idx[2:0]] = 1'b1;
                    found         = 1'b1;
                end
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer moves past the
// winner only when the caller reports that the grant was actually taken.
module rr_arbiter
    import ram_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0]      ptr_q, ptr_d;
    logic [MAX_REQ-1:0] req_ext;
    logic [MAX_REQ-1:0] sel;

    // Grant selection from the current pointer; forced off while in reset.
    always_comb begin
        req_ext        = '0;
        req_ext[N-1:0] = req;
        sel            = rr_select(req_ext, 3'(ptr_q), 4'(N));
        gnt            = resetn ? sel[N-1:0] : '0;
    end

    // Next pointer: one past the winner on a taken grant, otherwise hold.
    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            for (int i = 0; i < N; i++) begin
                if (sel[i]) ptr_d = (i == N - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) ptr_q <= '0;
        else         ptr_q <= ptr_d;
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the dual-port RAM's write and read ports between NUM_REQ clients per
// side. Commands are registered toward the RAM; read returns are steered back
// to the issuing client by a one-hot tag pipeline.
module ram_port_arbiter
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int NUM_REQ    = 2,
    parameter int RD_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [NUM_REQ-1:0]            wr_req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wr_data_i,
    output logic [NUM_REQ-1:0]            wr_gnt,
    input  logic [NUM_REQ-1:0]            rd_req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] rd_addr_i,
    output logic [NUM_REQ-1:0]            rd_gnt,
    output logic [NUM_REQ-1:0]            rd_valid,
    output logic [DATA_WIDTH-1:0]         rd_data_o,
    output logic                          write,
    output logic [ADDR_WIDTH-1:0]         wr_addr,
    output logic [DATA_WIDTH-1:0]         data_in,
    output logic                          read,
    output logic [ADDR_WIDTH-1:0]         rd_addr,
    input  logic [DATA_WIDTH-1:0]         ram_data_out
);

    logic [NUM_REQ-1:0]    rd_cand;
    logic [ADDR_WIDTH-1:0] wr_sel_addr, rd_sel_addr;
    logic [DATA_WIDTH-1:0] wr_sel_data;
    logic                  collide;
    logic                  wr_fire, rd_fire;

    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] data_in_q, data_in_d;
    logic                  read_q, read_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [NUM_REQ-1:0]    rd_valid_q, rd_valid_d;
    logic [RD_LATENCY:0][NUM_REQ-1:0] tag_q, tag_d;

    rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
        .clk     (clk),
        .resetn  (resetn),
        .req     (wr_req),
        .advance (wr_fire),
        .gnt     (wr_gnt)
    );

    // The read arbiter only advances when its candidate survives the
    // collision check, so its internal winner always matches rd_gnt.
    rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
        .clk     (clk),
        .resetn  (resetn),
        .req     (rd_req),
        .advance (rd_fire),
        .gnt     (rd_cand)
    );

    // Mux the winning client's address/data on each side.
    always_comb begin
        wr_sel_addr = '0;
        wr_sel_data = '0;
        rd_sel_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (wr_gnt[i]) begin
                wr_sel_addr = wr_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                wr_sel_data = wr_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
            if (rd_cand[i]) rd_sel_addr = rd_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    // A read to the address being written this cycle is deferred one cycle so
    // it is issued after the write lands and returns the new data.
    always_comb begin
        collide = (|wr_gnt) && (|rd_cand) && (wr_sel_addr == rd_sel_addr);
        rd_gnt  = collide ? '0 : rd_cand;
        wr_fire = |(wr_req & wr_gnt);
        rd_fire = |(rd_req & rd_gnt);
    end

    // Next-state for RAM commands and the read-return tag pipeline.
    always_comb begin
        write_d    = wr_fire;
        wr_addr_d  = wr_fire ? wr_sel_addr : wr_addr_q;
        data_in_d  = wr_fire ? wr_sel_data : data_in_q;
        read_d     = rd_fire;
        rd_addr_d  = rd_fire ? rd_sel_addr : rd_addr_q;
        tag_d      = '0;
        tag_d[0]   = rd_req & rd_gnt;
        for (int k = 1; k <= RD_LATENCY; k++) tag_d[k] = tag_q[k-1];
        rd_valid_d = tag_q[RD_LATENCY];
    end

    // Command, tag and return-valid registers; reset drops in-flight reads.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            write_q    <= 1'b0;
            wr_addr_q  <= '0;
            data_in_q  <= '0;
            read_q     <= 1'b0;
            rd_addr_q  <= '0;
            tag_q      <= '0;
            rd_valid_q <= '0;
        end else begin
            write_q    <= write_d;
            wr_addr_q  <= wr_addr_d;
            data_in_q  <= data_in_d;
            read_q     <= read_d;
            rd_addr_q  <= rd_addr_d;
            tag_q      <= tag_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign write     = write_q;
    assign wr_addr   = wr_addr_q;
    assign data_in   = data_in_q;
    assign read      = read_q;
    assign rd_addr   = rd_addr_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data_o = ram_data_out;

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Round-robin arbiter sharing the dual-port RAM's single write port and single read port between NUM_REQ write clients and NUM_REQ read clients.
- Sits between the client agents/masters and dualport_ram.
- Issues at most one write and one read command per cycle.
- Tags each read so the returning data is steered back to the requester that issued it.

Parameters:
- DATA_WIDTH, 64, RAM data width
- ADDR_WIDTH, 12, RAM address width (depth 4096)
- NUM_REQ, 2, requesters per side (2..8)
- RD_LATENCY, 1, cycles from ram_read sampled by RAM to ram_data_out valid (1..4)

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- wr_req  in  NUM_REQ  per-client write request, held until granted
- wr_addr_i  in  NUM_REQ*ADDR_WIDTH  packed write addresses, client i at slice i
- wr_data_i  in  NUM_REQ*DATA_WIDTH  packed write data
- wr_gnt  out  NUM_REQ  one-hot write grant (combinational)
- rd_req  in  NUM_REQ  per-client read request, held until granted
- rd_addr_i  in  NUM_REQ*ADDR_WIDTH  packed read addresses
- rd_gnt  out  NUM_REQ  one-hot read grant (combinational)
- rd_valid  out  NUM_REQ  one-hot, marks which client owns rd_data_o this cycle
- rd_data_o  out  DATA_WIDTH  read data, equal to ram_data_out
- write  out  1  RAM write strobe (registered)
- wr_addr  out  ADDR_WIDTH  RAM write address (registered)
- data_in  out  DATA_WIDTH  RAM write data (registered)
- read  out  1  RAM read strobe (registered)
- rd_addr  out  ADDR_WIDTH  RAM read address (registered)
- ram_data_out  in  DATA_WIDTH  RAM read data

Behaviour:
- Reset (resetn low, asynchronous):
  - write, read, wr_addr, rd_addr, data_in = 0; rd_valid = 0.
  - Tag pipeline flushed; both RR pointers = 0.
  - wr_gnt/rd_gnt = 0 while resetn low.
  - In-flight reads are dropped; no rd_valid appears after reset.
- Grant selection (per side, combinational):
  - Search starts at index ptr and wraps modulo NUM_REQ.
  - The first asserted req wins; at most one grant bit per side.
- Handshake:
  - A transfer occurs on a rising edge where req[i] & gnt[i].
  - The client may change address/data or drop req after that edge.
  - Dropping req before grant is legal and has no effect.
- Pointer update: on a transfer, ptr <= winner+1 (wraps to 0 after NUM_REQ-1). With no transfer, ptr holds.
- Issue timing, grant at edge t:
  - write/wr_addr/data_in valid for exactly the cycle after t.
  - read/rd_addr likewise.
  - With no grant, write/read = 0 next cycle; address/data hold their last values.
- Read return:
  - Tag shift register of depth RD_LATENCY+1 carries the one-hot client id.
  - rd_valid is asserted exactly RD_LATENCY+1 cycles after the read-grant edge, for one cycle.
  - rd_data_o = ram_data_out passes through unregistered.
- Address collision:
  - Applies when a write and a read are both selected in the same cycle with equal addresses.
  - rd_gnt is forced to 0 that cycle and the read pointer holds; the write proceeds.
  - The read is granted the following cycle and returns the new data.
- Back-to-back: one write and one read may issue every cycle indefinitely; no bubbles except collisions.
- Single requester continuously asserting: granted every cycle.
- With all clients requesting, each client is granted once per NUM_REQ cycles.

Decomposition:
- ram_pkg holds:
  - DATA_WIDTH/ADDR_WIDTH defaults
  - typedef addr_t and data_t
  - function rr_select(req, ptr) returning a one-hot grant
- One sub-module, rr_arbiter:
  - Parameter N; ports clk, resetn, req, advance, gnt.
  - Owns the pointer.
  - Instantiated twice: write side and read side.

Test Plan:
- Reset: hold resetn low 3 cycles with all req=1 -> wr_gnt=rd_gnt=0, write=read=0, rd_valid=0. Release -> first grants go to client 0 on both sides.
- Fairness: NUM_REQ=2, both wr_req held high 6 cycles -> wr_gnt sequence 01,10,01,10,01,10. write asserted 6 consecutive cycles starting 1 cycle after the first grant.
- Write/read round trip: client1 writes addr 0x00A data 0xDEAD_BEEF_0000_0001. Later client0 reads 0x00A -> rd_valid=01 exactly 2 cycles after the read-grant edge (RD_LATENCY=1), rd_data_o=0xDEAD_BEEF_0000_0001.
- Collision: same cycle wr_req[0] addr 0x055 data 0x1234 and rd_req[1] addr 0x055 -> rd_gnt=0 that cycle, rd_gnt=10 next cycle; returned data 0x1234.
- Wrap/pointer: NUM_REQ=4, only client 3 then client 0 request -> ptr 0->0 (client 3 granted, ptr wraps to 0), then client 0 granted.
- Reset mid-read: assert resetn low 1 cycle after a read grant -> no rd_valid ever appears; the next read after release returns correct data.
